// File: rtl/imm_pkg.sv
// Shared types and the immediate-extraction function for the decode-stage immediate generator.
package imm_pkg;

  typedef enum logic [2:0] {
    IMM_I = 3'b000,
    IMM_S = 3'b001,
    IMM_B = 3'b010,
    IMM_U = 3'b011,
    IMM_J = 3'b100,
    IMM_Z = 3'b101
  } imm_src_t;

  typedef enum logic [1:0] {
    BUF_EMPTY = 2'b00,
    BUF_ONE   = 2'b01,
    BUF_FULL  = 2'b10
  } buf_state_t;

  // Returns {err, imm[31:0]}. Every legal format carries its sign in bit 31
  // (Z has bit 31 clear), so the caller widens to XLEN by sign extension.
  function automatic logic [32:0] imm_extract(input logic [31:0] instr,
                                              input logic [2:0]  src);
    logic [19:0] sx;
    logic [31:0] imm;
    logic        err;
    sx  = {20{instr[31]}};
    imm = '0;
    err = 1'b0;
    case (imm_src_t'(src))
      IMM_I:   imm = {sx, instr[31:20]};
      IMM_S:   imm = {sx, instr[31:25], instr[11:7]};
      IMM_B:   imm = {sx[18:0], instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U:   imm = {instr[31:12], 12'b0};
      IMM_J:   imm = {sx[10:0], instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      IMM_Z:   imm = {27'b0, instr[19:15]};
      default: err = 1'b1;
    endcase
    return {err, imm};
  endfunction

endpackage

// File: rtl/skid_buf.sv
// Two-slot valid/ready buffer (output register plus skid register), strictly FIFO.
module skid_buf
  import imm_pkg::*;
#(
  parameter int W = 41
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [W-1:0] in_data_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] out_data_o
);

  buf_state_t   state_q, state_d;
  logic [W-1:0] out_q, out_d;
  logic [W-1:0] skid_q, skid_d;
  logic         acc, pop;

  // Both handshake flags are pure decodes of the registered state.
  assign in_ready_o  = (state_q != BUF_FULL);
  assign out_valid_o = (state_q != BUF_EMPTY);
  assign out_data_o  = out_q;

  assign acc = in_valid_i & in_ready_o;
  assign pop = out_valid_o & out_ready_i;

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    skid_d  = skid_q;
    case (state_q)
      BUF_EMPTY: begin
        if (acc) begin
          out_d   = in_data_i;
          state_d = BUF_ONE;
        end
      end
      BUF_ONE: begin
        if (acc && pop) begin
          out_d = in_data_i;
        end else if (acc) begin
          skid_d  = in_data_i;
          state_d = BUF_FULL;
        end else if (pop) begin
          state_d = BUF_EMPTY;
        end
      end
      BUF_FULL: begin
        if (pop) begin
          out_d   = skid_q;
          state_d = BUF_ONE;
        end
      end
      default: state_d = BUF_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= BUF_EMPTY;
      out_q   <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      skid_q  <= skid_d;
    end
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// Decode-stage immediate generator: combinational extract into a skid-buffered output register.
module imm_gen_pipe
  import imm_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [2:0]       in_imm_src,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_err
);

  if (XLEN != 32 && XLEN != 64) begin : g_xlen_chk
    $fatal(1, "imm_gen_pipe: XLEN must be 32 or 64");
  end

  localparam int PAY_W = XLEN + TAG_W + 1;

  logic [32:0]        ext;
  logic signed [31:0] imm32;
  logic [XLEN-1:0]    imm_x;
  logic [PAY_W-1:0]   pay_in, pay_out;

  assign ext   = imm_extract(in_instr, in_imm_src);
  assign imm32 = ext[31:0];
  assign imm_x = XLEN'(imm32);
  assign pay_in = {ext[32], imm_x, in_tag};

  skid_buf #(.W(PAY_W)) u_buf (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_data_i   (pay_in),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_data_o  (pay_out)
  );

  assign {out_err, out_imm, out_tag} = pay_out;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Scoreboard bench for imm_gen_pipe: XLEN=32 and XLEN=64 instances share stimulus and one reference queue.
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] in_instr;
  logic [2:0]  in_imm_src;
  logic [7:0]  in_tag;
  logic        out_ready;

  logic        in_ready32, out_valid32, out_err32;
  logic [31:0] out_imm32;
  logic [7:0]  out_tag32;
  logic        in_ready64, out_valid64, out_err64;
  logic [63:0] out_imm64;
  logic [7:0]  out_tag64;

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .TAG_W(8)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready32),
    .in_instr(in_instr), .in_imm_src(in_imm_src), .in_tag(in_tag),
    .out_valid(out_valid32), .out_ready(out_ready), .out_imm(out_imm32),
    .out_tag(out_tag32), .out_err(out_err32)
  );

  imm_gen_pipe #(.XLEN(64), .TAG_W(8)) u_dut64 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready64),
    .in_instr(in_instr), .in_imm_src(in_imm_src), .in_tag(in_tag),
    .out_valid(out_valid64), .out_ready(out_ready), .out_imm(out_imm64),
    .out_tag(out_tag64), .out_err(out_err64)
  );

  typedef struct {
    logic [63:0] imm;
    logic        err;
    logic [7:0]  tag;
  } exp_t;

  exp_t sbq[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  bit   rand_done;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Reference: arithmetic on a 64-bit sign-extended copy of the instruction.
  function automatic exp_t model(input logic [31:0] ins, input logic [2:0] src,
                                 input logic [7:0] tag);
    exp_t   e;
    longint s;
    longint r;
    s = longint'($signed(ins));
    r = 0;
    e.err = 1'b0;
    case (src)
      3'd0: r = s >>> 20;
      3'd1: r = ((s >>> 25) <<< 5) | longint'(ins[11:7]);
      3'd2: r = ((s >>> 31) <<< 12) | (longint'(ins[7]) << 11)
              | (longint'(ins[30:25]) << 5) | (longint'(ins[11:8]) << 1);
      3'd3: r = (s >>> 12) <<< 12;
      3'd4: r = ((s >>> 31) <<< 20) | (longint'(ins[19:12]) << 12)
              | (longint'(ins[20]) << 11) | (longint'(ins[30:21]) << 1);
      3'd5: r = longint'(ins[19:15]);
      default: begin r = 0; e.err = 1'b1; end
    endcase
    e.imm = r;
    e.tag = tag;
    return e;
  endfunction

  // Issue tracker: record each accepted word; a reset edge discards everything queued.
  always @(negedge clk) begin
    if (rst_n === 1'b0) begin
      sbq.delete();
    end else if (in_valid && in_ready32) begin
      chk("in_ready_64_vs_32", in_ready64, in_ready32);
      sbq.push_back(model(in_instr, in_imm_src, in_tag));
    end
  end

  // Output monitor: every transferred word must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid32 && out_ready) begin
      if (sbq.size() == 0) begin
        chk("unexpected_output_tag", out_tag32, 8'hxx);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("valid64", out_valid64, 1'b1);
        chk("imm32", out_imm32, e.imm[31:0]);
        chk("imm64", out_imm64, e.imm);
        chk("tag32", out_tag32, e.tag);
        chk("tag64", out_tag64, e.tag);
        chk("err32", out_err32, e.err);
        chk("err64", out_err64, e.err);
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 right after the accepting edge.
  task automatic send(input logic [31:0] ins, input logic [2:0] src, input logic [7:0] tag);
    bit ok;
    ok = 1'b0;
    in_valid   = 1'b1;
    in_instr   = ins;
    in_imm_src = src;
    in_tag     = tag;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (in_ready32) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("send_timeout_in_ready", in_ready32, 1'b1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_instr = $urandom;
  endtask

  task automatic directed(input logic [31:0] ins, input logic [2:0] src, input logic [7:0] tag,
                          input logic [31:0] e32, input logic [63:0] e64, input logic eerr);
    send(ins, src, tag);
    @(negedge clk);
    chk("dir_valid", out_valid32, 1'b1);
    chk("dir_imm32", out_imm32, e32);
    chk("dir_imm64", out_imm64, e64);
    chk("dir_tag", out_tag32, tag);
    chk("dir_err", out_err32, eerr);
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (sbq.size() == 0) break;
    end
    chk("drain_queue_empty", sbq.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    in_instr   = '0;
    in_imm_src = '0;
    in_tag     = '0;
    out_ready  = 1'b1;
    rand_done  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", out_valid32, 1'b0);
    chk("rst_in_ready", in_ready32, 1'b1);
    chk("rst_out_imm", out_imm64, 64'h0);
    chk("rst_out_tag", out_tag32, 8'h0);
    chk("rst_out_err", out_err32, 1'b0);
    @(posedge clk);
    #1;

    directed(32'hFFF00093, 3'b000, 8'h11, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b0);
    directed(32'hFE512E23, 3'b001, 8'h22, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 1'b0);
    directed(32'hFE000CE3, 3'b010, 8'h33, 32'hFFFFFFF8, 64'hFFFFFFFFFFFFFFF8, 1'b0);
    directed(32'h001000EF, 3'b100, 8'h44, 32'h00000800, 64'h0000000000000800, 1'b0);
    directed(32'h000FD073, 3'b101, 8'h55, 32'h0000001F, 64'h000000000000001F, 1'b0);
    directed(32'h800000B7, 3'b011, 8'h66, 32'h80000000, 64'hFFFFFFFF80000000, 1'b0);
    directed(32'hDEADBEEF, 3'b110, 8'h77, 32'h0, 64'h0, 1'b1);
    directed(32'hCAFEF00D, 3'b111, 8'h78, 32'h0, 64'h0, 1'b1);
    directed(32'hFFF00093, 3'b000, 8'h79, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b0);
    drain();

    // Back-pressure: six back-to-back words, out_ready low for three edges.
    out_ready = 1'b0;
    fork
      begin
        for (int t = 1; t <= 6; t++) send($urandom, 3'($urandom_range(0, 5)), 8'(t));
      end
      begin
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("bp_in_ready_low", in_ready32, 1'b0);
        chk("bp_out_valid", out_valid32, 1'b1);
        chk("bp_out_tag_held", out_tag32, 8'd1);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // Randomized traffic with random gaps and random back-pressure.
    fork
      begin
        for (int i = 0; i < 400; i++) begin
          int gap;
          gap = $urandom_range(0, 3) == 0 ? $urandom_range(1, 3) : 0;
          for (int g = 0; g < gap; g++) begin
            in_instr = $urandom;
            @(posedge clk);
            #1;
          end
          send($urandom, 3'($urandom_range(0, 7)), 8'($urandom));
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_ready = 1'b1;
    drain();

    // Reset while FULL discards both slots.
    out_ready = 1'b0;
    send($urandom, 3'd0, 8'hA1);
    send($urandom, 3'd1, 8'hA2);
    @(negedge clk);
    chk("full_in_ready_low", in_ready32, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("rst_full_out_valid", out_valid32, 1'b0);
    chk("rst_full_in_ready", in_ready32, 1'b1);
    chk("rst_full_out_imm", out_imm64, 64'h0);
    chk("rst_full_out_tag", out_tag32, 8'h0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("no_stale_out_valid", out_valid32, 1'b0);
    end
    chk("queue_empty_after_reset", sbq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
